// File: rtl/rr_arb_mux.sv
// rr_arb_mux: registered N-to-1 channel multiplexer with valid/ready
// handshakes on every input and on the output.
//
// A single output register sits between NCH requesters and one consumer.
// Grants come either from an explicit channel index (iMode=0) or from a
// round-robin scan that starts just after the last granted channel (iMode=1).
// The output register reloads in the same cycle the consumer accepts, so a
// steady stream moves one word per cycle with no bubble.
//
// Ports:
//   iCLK      clock, rising edge active
//   iRST      asynchronous active-high reset
//   iMode     0 = explicit select, 1 = round-robin
//   iSelect   channel index used when iMode=0 (>= NCH is never granted)
//   iValid    per-channel request valid
//   iData     flattened channel data, channel k at [k*WIDTH +: WIDTH]
//   oReady    per-channel accept, one-hot or zero, combinational
//   oValid    output register holds valid data
//   oData     registered selected data
//   oChannel  index of the channel that supplied oData
//   iReady    consumer accepts oData this cycle
module rr_arb_mux #(
  parameter int WIDTH = 32,
  parameter int NCH   = 8,
  parameter int SELW  = 3
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iMode,
  input  logic [SELW-1:0]      iSelect,
  input  logic [NCH-1:0]       iValid,
  input  logic [NCH*WIDTH-1:0] iData,
  output logic [NCH-1:0]       oReady,
  output logic                 oValid,
  output logic [WIDTH-1:0]     oData,
  output logic [SELW-1:0]      oChannel,
  input  logic                 iReady
);

  localparam int NSEL = 2**SELW;

  typedef enum logic {EMPTY, FULL} state_t;

  state_t            state, state_nxt;
  logic [SELW-1:0]   last;
  logic              load;
  logic              gnt_ok;
  logic [SELW-1:0]   gnt;
  logic [WIDTH-1:0]  gnt_data;
  logic [NSEL-1:0]   valid_ext;

  // Widened so that any SELW-bit index is in range; the padding bits are
  // zero, which is what keeps an out-of-range iSelect from ever granting.
  assign valid_ext = NSEL'(iValid);

  // Grant selection. The round-robin scan walks offsets from the farthest
  // to the nearest so that the nearest valid channel after 'last' wins.
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // values just computed; clocked blocks use '<=' so every register samples
  // pre-edge values regardless of statement order.
  always_comb begin
    logic [SELW:0] idx;
    gnt_ok = 1'b0;
    gnt    = '0;
    idx    = '0;
    if (!iMode) begin
      if (int'(iSelect) < NCH && valid_ext[iSelect]) begin
        gnt_ok = 1'b1;
        gnt    = iSelect;
      end
    end else begin
      for (int i = NCH; i >= 1; i--) begin
        idx = {1'b0, last} + (SELW+1)'(i);
        if (idx >= (SELW+1)'(NCH)) idx = idx - (SELW+1)'(NCH);
        if (valid_ext[idx[SELW-1:0]]) begin
          gnt_ok = 1'b1;
          gnt    = idx[SELW-1:0];
        end
      end
    end
  end

  // Data mux written as a compare loop so no index can run past NCH.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt == SELW'(k)) gnt_data = iData[k*WIDTH +: WIDTH];
    end
  end

  // Next state and handshake outputs. oReady depends on iReady only through
  // 'load'; producers must not feed oReady back into iValid.
  // NOTE: every output of an always_comb gets a default on entry; a path
  // that leaves one unassigned would infer a latch.
  always_comb begin
    load      = (state == EMPTY) || iReady;
    state_nxt = state;
    oReady    = '0;
    if (load) begin
      state_nxt = gnt_ok ? FULL : EMPTY;
      // The state register is already EMPTY during reset, so 'load' alone
      // would let oReady assert; iRST masks it explicitly.
      if (gnt_ok && !iRST) oReady = NCH'(1) << gnt;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= EMPTY;
      oData    <= '0;
      oChannel <= '0;
      last     <= SELW'(NCH-1);
    end else begin
      state <= state_nxt;
      if (load && gnt_ok) begin
        oData    <= gnt_data;
        oChannel <= gnt;
        last     <= gnt;
      end
    end
  end

  assign oValid = (state == FULL);

endmodule

// File: tb/tb_rr_arb_mux.sv
// Self-checking bench for rr_arb_mux: directed cases from the block's
// behaviour list, then randomized traffic against a reference model. The
// driver pushes each expected output word into a queue at grant time; an
// independent monitor pops and compares whenever the consumer accepts.
module tb_rr_arb_mux;

  localparam int W = 32;
  localparam int N = 8;
  localparam int S = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mode;
  logic [S-1:0]     sel;
  logic [N-1:0]     valid;
  logic [N*W-1:0]   data;
  logic [N-1:0]     ordy;
  logic             ovalid;
  logic [W-1:0]     odata;
  logic [S-1:0]     ochan;
  logic             ready;

  // Six-channel build, used for out-of-range select indices.
  logic             mode6;
  logic [S-1:0]     sel6;
  logic [5:0]       valid6;
  logic [6*W-1:0]   data6;
  logic [5:0]       ordy6;
  logic             ovalid6;
  logic [W-1:0]     odata6;
  logic [S-1:0]     ochan6;
  logic             ready6;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(W), .NCH(N), .SELW(S)) dut (
    .iCLK(clk), .iRST(rst), .iMode(mode), .iSelect(sel), .iValid(valid),
    .iData(data), .oReady(ordy), .oValid(ovalid), .oData(odata),
    .oChannel(ochan), .iReady(ready)
  );

  rr_arb_mux #(.WIDTH(W), .NCH(6), .SELW(S)) dut6 (
    .iCLK(clk), .iRST(rst), .iMode(mode6), .iSelect(sel6), .iValid(valid6),
    .iData(data6), .oReady(ordy6), .oValid(ovalid6), .oData(odata6),
    .oChannel(ochan6), .iReady(ready6)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic [S-1:0] ch;
  } exp_t;

  int          total = 0;
  int          bad   = 0;
  exp_t        sbq[$];
  logic [W-1:0] chd [N];   // data currently driven per channel
  logic [W-1:0] nd  [N];   // data to drive from the next step on
  bit          m_full;
  int          m_last;
  bit          track;
  int          wt [N];
  int          maxwait;

  always_comb begin
    for (int k = 0; k < N; k++) data[k*W +: W] = chd[k];
  end

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference grant: explicit index if requesting, else the first requester
  // at distance 1..N after the last grant, modulo N.
  function automatic int model_grant(input bit md, input int sl,
                                     input logic [N-1:0] v);
    if (!md) return (sl < N && v[sl]) ? sl : -1;
    for (int off = 1; off <= N; off++) begin
      int k;
      k = (m_last + off) % N;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r == (N'(1) << k)) return k;
    return -1;
  endfunction

  // One clock cycle of stimulus: drive just after the edge, check the
  // combinational handshake, predict the edge's outcome.
  task automatic step(input bit md, input int sl, input logic [N-1:0] v,
                      input bit rdy, output int g);
    bit          load;
    logic [N-1:0] exp_r;
    @(posedge clk);
    #1;
    mode  = md;
    sel   = S'(sl);
    valid = v;
    ready = rdy;
    for (int k = 0; k < N; k++) chd[k] = nd[k];
    #1;
    check("ovalid", 64'(ovalid), 64'(m_full));
    load  = !m_full || rdy;
    g     = load ? model_grant(md, sl, v) : -1;
    exp_r = (g >= 0) ? (N'(1) << g) : '0;
    check("oready", 64'(ordy), 64'(exp_r));
    if (track) begin
      for (int k = 0; k < N; k++) begin
        if (v[k]) begin
          if (ordy[k]) wt[k] = 0;
          else if (ordy != '0) begin
            wt[k]++;
            if (wt[k] > maxwait) maxwait = wt[k];
          end
        end
      end
    end
    if (g >= 0) begin
      sbq.push_back('{d: chd[g], ch: S'(g)});
      m_last = g;
      m_full = 1'b1;
    end else if (load) begin
      m_full = 1'b0;
    end
  endtask

  // Monitor: an accept happens on the next edge whenever oValid and iReady
  // are both high mid-cycle.
  always @(negedge clk) begin
    if (!rst && ovalid && ready) begin
      if (sbq.size() == 0) begin
        check("sb_underflow", 64'(sbq.size()), 64'd1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("odata", 64'(odata), 64'(e.d));
        check("ochannel", 64'(ochan), 64'(e.ch));
      end
    end
  end

  initial begin
    int g;
    int seq [6];
    logic [N-1:0] pend;
    seq = '{0, 3, 7, 0, 3, 7};
    mode = 1'b0; sel = '0; valid = '1; ready = 1'b1;
    mode6 = 1'b0; sel6 = '0; valid6 = '0; data6 = '0; ready6 = 1'b1;
    for (int k = 0; k < N; k++) begin
      nd[k]  = $urandom;
      chd[k] = nd[k];
    end
    m_full = 1'b0; m_last = N-1; track = 1'b0; maxwait = 0;
    for (int k = 0; k < N; k++) wt[k] = 0;

    // Reset state, with a request present that must not raise oReady.
    #1;
    check("rst_ovalid", 64'(ovalid), 64'd0);
    check("rst_odata", 64'(odata), 64'd0);
    check("rst_ochan", 64'(ochan), 64'd0);
    check("rst_oready", 64'(ordy), 64'd0);
    valid = '0;
    @(negedge clk);
    rst = 1'b0;

    // Six-channel build: index 2 is granted, 6 and 7 never are.
    @(posedge clk); #1;
    sel6 = 3'd2; valid6 = '1; data6[2*W +: W] = 32'hAAAA_5555;
    #1;
    check("n6_sel2_ordy", 64'(ordy6), 64'h04);
    @(posedge clk); #1;
    sel6 = 3'd7;
    #1;
    check("n6_sel7_ordy", 64'(ordy6), 64'h00);
    check("n6_held_valid", 64'(ovalid6), 64'd1);
    check("n6_held_data", 64'(odata6), 64'hAAAA_5555);
    check("n6_held_chan", 64'(ochan6), 64'd2);
    @(posedge clk); #1;
    sel6 = 3'd6;
    #1;
    check("n6_drained", 64'(ovalid6), 64'd0);
    check("n6_sel6_ordy", 64'(ordy6), 64'h00);

    // Explicit select of channel 5, back to back.
    nd[5] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 5, 8'hFF, 1'b1, g);
      check("sel5_ordy", 64'(ordy), 64'h20);
      if (i > 0) begin
        check("sel5_valid", 64'(ovalid), 64'd1);
        check("sel5_data", 64'(odata), 64'hDEAD_BEEF);
        check("sel5_chan", 64'(ochan), 64'd5);
      end
    end

    // Asynchronous reset in the middle of a cycle while FULL.
    @(negedge clk); #2;
    rst = 1'b1; valid = '0;
    #1;
    check("arst_ovalid", 64'(ovalid), 64'd0);
    check("arst_odata", 64'(odata), 64'd0);
    check("arst_ochan", 64'(ochan), 64'd0);
    check("arst_oready", 64'(ordy), 64'd0);
    sbq.delete();
    m_full = 1'b0; m_last = N-1;
    @(negedge clk);
    rst = 1'b0;

    // Round-robin order and wrap from reset, then a lone requester.
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 0, 8'b1000_1001, 1'b1, g);
      check("rr_order", 64'(onehot_idx(ordy)), 64'(seq[i]));
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 0, 8'b0000_0001, 1'b1, g);
      check("rr_single", 64'(onehot_idx(ordy)), 64'd0);
    end

    // Backpressure holding channel 2, then release with channel 3 next.
    nd[2] = 32'h1234_5678;
    step(1'b0, 2, 8'hFF, 1'b1, g);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 0, 8'hFF, 1'b0, g);
      check("bp_ordy", 64'(ordy), 64'h00);
      check("bp_valid", 64'(ovalid), 64'd1);
      check("bp_data", 64'(odata), 64'h1234_5678);
      check("bp_chan", 64'(ochan), 64'd2);
    end
    step(1'b1, 0, 8'hFF, 1'b1, g);
    check("bp_release_ordy", 64'(ordy), 64'h08);
    step(1'b1, 0, 8'h00, 1'b1, g);
    check("bp_next_valid", 64'(ovalid), 64'd1);
    check("bp_next_chan", 64'(ochan), 64'd3);
    step(1'b1, 0, 8'h00, 1'b1, g);
    check("noreq_valid", 64'(ovalid), 64'd0);

    // Random round-robin traffic; requests stay up until granted.
    track = 1'b1;
    pend  = '0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!pend[k] && $urandom_range(2) == 0) begin
          pend[k] = 1'b1;
          nd[k]   = $urandom;
        end
      end
      step(1'b1, 0, pend, ($urandom_range(3) != 0), g);
      if (g >= 0) pend[g] = 1'b0;
    end
    track = 1'b0;
    check("starvation_bound", 64'(maxwait <= N-1), 64'd1);

    // Random mixed-mode traffic, including mode and select changes while FULL.
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) nd[k] = $urandom;
      step(1'($urandom_range(1)), $urandom_range(N-1), N'($urandom),
           ($urandom_range(3) != 0), g);
    end

    // Drain: every predicted word must have been accepted exactly once.
    for (int i = 0; i < 3; i++) step(1'b1, 0, 8'h00, 1'b1, g);
    @(negedge clk); #1;
    check("drain_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
- Parametrised, registered N-to-1 channel multiplexer with a valid/ready handshake on every input and on the output.
- Two grant modes: explicit select, or round-robin arbitration.
- Sits between multiple requesters (instruction fetch, data access, debug/DMA) and a shared consumer such as the memory bus.
- Generalises the combinational 8:1 selector: width and channel count are parameters, the output is registered, and data is held until the consumer accepts it.

Parameters:
- WIDTH, 32, data width per channel.
- NCH, 8, number of input channels (2..16).
- SELW, 3, select/channel-index width; must satisfy 2**SELW >= NCH.

Ports:
- iCLK  input  1  clock; all state changes on its rising edge.
- iRST  input  1  asynchronous, active-high reset.
- iMode  input  1  0 = explicit select, 1 = round-robin.
- iSelect  input  SELW  channel index used when iMode=0.
- iValid  input  NCH  per-channel request valid.
- iData  input  NCH*WIDTH  flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- oReady  output  NCH  per-channel accept; one-hot or zero, combinational.
- oValid  output  1  output register holds valid data.
- oData  output  WIDTH  registered selected data.
- oChannel  output  SELW  index of the channel that supplied oData.
- iReady  input  1  consumer accepts oData this cycle.

Behaviour:
- Reset (asynchronous, while iRST=1):
  - oValid=0, oData=0, oChannel=0.
  - Round-robin pointer last=NCH-1, so channel 0 has first priority after reset.
  - oReady=0 while iRST is high.
- State machine: EMPTY (oValid=0) and FULL (oValid=1).
- Load enable: load = EMPTY, or (FULL and iReady). Throughput is one transfer per cycle with no bubble.
- Grant, evaluated combinationally only when load=1:
  - iMode=0: grant g=iSelect if iSelect<NCH and iValid[iSelect]=1; otherwise no grant.
  - iMode=1: g = first k with iValid[k]=1, scanning last+1, last+2, ... modulo NCH. No grant if iValid=0.
- oReady[g]=1 only when load and a grant exist. All other oReady bits are 0, and all bits are 0 when load=0.
- On a rising edge with a grant: oData<=iData[g], oChannel<=g, oValid<=1, last<=g in both modes. Latency: input handshake in cycle n, data visible at oData in cycle n+1.
- On a rising edge with load=1 and no grant: oValid<=0. oData and oChannel keep their values (don't-care when oValid=0).
- FULL and iReady=0: oData, oChannel and oValid are held stable, and no input is accepted (backpressure).
- Simultaneous output accept and new grant: the new value replaces the old in the same edge and oValid stays 1.
- Wrap-around: with last=NCH-1 the scan starts at channel 0. With a single requester, that channel is granted every cycle.
- Mode or iSelect change while FULL: held data is unaffected; the new mode applies at the next load.
- Out-of-range iSelect (>=NCH) in mode 0: never granted and never drives oReady. This is not an error.
- Reset asserted mid-transfer: held data is dropped immediately, oValid=0 asynchronously. No transfer completes on the edge where iRST is high.
- The design must not create a combinational path from iReady through oReady back into iValid. Producers must not make iValid depend on oReady.

Test Plan:
- Reset/idle: iRST pulsed mid-cycle with oValid=1 -> oValid=0, oData=0, oChannel=0, oReady=0 immediately, without waiting for a clock edge.
- Explicit select, 1-cycle latency: iMode=0, iSelect=5, iValid=8'hFF, channel 5 data=32'hDEAD_BEEF, iReady=1 -> oReady=8'b0010_0000; next cycle oValid=1, oData=32'hDEADBEEF, oChannel=5; repeats each cycle with no bubble.
- Round-robin fairness and wrap:
  - iMode=1, iValid=8'b1000_1001, iReady=1 from reset -> grant order 0,3,7,0,3,7.
  - Then iValid=8'b0000_0001 -> channel 0 every cycle.
- Backpressure: FULL holding channel 2 data 32'h1234_5678, iReady=0 for 4 cycles while iValid=8'hFF -> oData/oChannel/oValid stable and oReady=0. iReady=1 -> channel 2's value is consumed, channel 3 is granted on the same edge, and oValid stays 1.
- Invalid select/no request:
  - iMode=0, NCH=6 build, iSelect=7 -> oReady=0 and oValid goes to 0 after the held word drains.
  - iMode=1, iValid=0 -> oValid=0.
- Parameter sweep: WIDTH=8/NCH=3/SELW=2 and WIDTH=64/NCH=16/SELW=4 -> random valid/ready traffic checked against a scoreboard model: no lost or duplicated words, and a round-robin starvation bound of NCH grants.
